// File: rtl/kbd_ascii_fifo_if.sv
// Bus between the PS/2 driver / MCU side and the scancode-to-ASCII FIFO.
// The master side drives scancodes and pop requests; the slave side is the translator.
interface kbd_ascii_fifo_if #(
  parameter int DEPTH = 8
);
  logic                     CODE_VALID;
  logic [7:0]               SCANCODE;
  logic                     RD_EN;
  logic                     OVF_CLR;
  logic [7:0]               DATA_OUT;
  logic                     EMPTY;
  logic                     FULL;
  logic [$clog2(DEPTH):0]   COUNT;
  logic                     IRQ;
  logic                     OVF;
  logic                     CAPS_LED;

  modport master (
    output CODE_VALID, SCANCODE, RD_EN, OVF_CLR,
    input  DATA_OUT, EMPTY, FULL, COUNT, IRQ, OVF, CAPS_LED
  );

  modport slave (
    input  CODE_VALID, SCANCODE, RD_EN, OVF_CLR,
    output DATA_OUT, EMPTY, FULL, COUNT, IRQ, OVF, CAPS_LED
  );
endinterface

// File: rtl/kbd_ascii_fifo.sv
// PS/2 scancode decoder (shift / caps / break / extended prefixes) feeding an
// ASCII character FIFO read by the MCU through a pop handshake.
module kbd_ascii_fifo #(
  parameter int DEPTH = 8
) (
  input  logic           CLK,
  input  logic           reset,
  kbd_ascii_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cv_q;
  logic            r_shift_l, r_shift_r, r_caps;
  logic            w_shift_l_nxt, w_shift_r_nxt, w_caps_nxt;
  logic            w_event, w_push, w_do_push, w_do_pop, w_ovf_set, w_full;
  logic [9:0]      w_lut;
  logic [7:0]      w_char;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  // {mapped, is_letter, lowercase/plain character}
  function automatic logic [9:0] f_lookup(input logic [7:0] code);
    case (code)
      8'h1C: f_lookup = {2'b11, 8'h61};  8'h32: f_lookup = {2'b11, 8'h62};
      8'h21: f_lookup = {2'b11, 8'h63};  8'h23: f_lookup = {2'b11, 8'h64};
      8'h24: f_lookup = {2'b11, 8'h65};  8'h2B: f_lookup = {2'b11, 8'h66};
      8'h34: f_lookup = {2'b11, 8'h67};  8'h33: f_lookup = {2'b11, 8'h68};
      8'h43: f_lookup = {2'b11, 8'h69};  8'h3B: f_lookup = {2'b11, 8'h6A};
      8'h42: f_lookup = {2'b11, 8'h6B};  8'h4B: f_lookup = {2'b11, 8'h6C};
      8'h3A: f_lookup = {2'b11, 8'h6D};  8'h31: f_lookup = {2'b11, 8'h6E};
      8'h44: f_lookup = {2'b11, 8'h6F};  8'h4D: f_lookup = {2'b11, 8'h70};
      8'h15: f_lookup = {2'b11, 8'h71};  8'h2D: f_lookup = {2'b11, 8'h72};
      8'h1B: f_lookup = {2'b11, 8'h73};  8'h2C: f_lookup = {2'b11, 8'h74};
      8'h3C: f_lookup = {2'b11, 8'h75};  8'h2A: f_lookup = {2'b11, 8'h76};
      8'h1D: f_lookup = {2'b11, 8'h77};  8'h22: f_lookup = {2'b11, 8'h78};
      8'h35: f_lookup = {2'b11, 8'h79};  8'h1A: f_lookup = {2'b11, 8'h7A};
      8'h45: f_lookup = {2'b10, 8'h30};  8'h16: f_lookup = {2'b10, 8'h31};
      8'h1E: f_lookup = {2'b10, 8'h32};  8'h26: f_lookup = {2'b10, 8'h33};
      8'h25: f_lookup = {2'b10, 8'h34};  8'h2E: f_lookup = {2'b10, 8'h35};
      8'h36: f_lookup = {2'b10, 8'h36};  8'h3D: f_lookup = {2'b10, 8'h37};
      8'h3E: f_lookup = {2'b10, 8'h38};  8'h46: f_lookup = {2'b10, 8'h39};
      8'h29: f_lookup = {2'b10, 8'h20};  8'h5A: f_lookup = {2'b10, 8'h0D};
      8'h66: f_lookup = {2'b10, 8'h08};
      default: f_lookup = '0;
    endcase
  endfunction

  assign w_event = bus.CODE_VALID & ~r_cv_q;
  assign w_lut   = f_lookup(bus.SCANCODE);
  assign w_char  = (w_lut[8] & ((r_shift_l | r_shift_r) ^ r_caps)) ? (w_lut[7:0] - 8'h20)
                                                                    : w_lut[7:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_l_nxt = r_shift_l;
    w_shift_r_nxt = r_shift_r;
    w_caps_nxt    = r_caps;
    w_push        = 1'b0;
    if (w_event) begin
      case (r_state)
        S_IDLE: begin
          case (bus.SCANCODE)
            8'hF0:   w_state_nxt   = S_BREAK;
            8'hE0:   w_state_nxt   = S_EXT;
            8'h12:   w_shift_l_nxt = 1'b1;
            8'h59:   w_shift_r_nxt = 1'b1;
            8'h58:   w_caps_nxt    = ~r_caps;
            default: w_push        = w_lut[9];
          endcase
        end
        S_BREAK: begin
          if (bus.SCANCODE == 8'h12) w_shift_l_nxt = 1'b0;
          if (bus.SCANCODE == 8'h59) w_shift_r_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
        S_EXT:   w_state_nxt = (bus.SCANCODE == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cv_q    <= 1'b0;
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
      r_caps    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cv_q    <= bus.CODE_VALID;
      r_shift_l <= w_shift_l_nxt;
      r_shift_r <= w_shift_r_nxt;
      r_caps    <= w_caps_nxt;
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = bus.RD_EN & (r_count != '0);
  assign w_do_push = w_push & (~w_full | w_do_pop);
  assign w_ovf_set = w_push & w_full & ~w_do_pop;

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_char;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.OVF_CLR) r_ovf <= 1'b0;
    end
  end

  assign bus.DATA_OUT = (r_count == '0) ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.EMPTY    = (r_count == '0);
  assign bus.FULL     = w_full;
  assign bus.COUNT    = r_count;
  assign bus.IRQ      = (r_count != '0);
  assign bus.OVF      = r_ovf;
  assign bus.CAPS_LED = r_caps;
endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Bench for kbd_ascii_fifo: directed scenarios then random keystrokes, all
// compared every cycle against a queue-based keyboard model.
module tb_kbd_ascii_fifo;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  kbd_ascii_fifo_if #(.DEPTH(DEPTH)) bus ();
  kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (.CLK(CLK), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  byte unsigned letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};

  // model: pending characters plus modifier and prefix flags
  byte unsigned q[$];
  bit m_shl, m_shr, m_caps, m_brk, m_ext, m_cvq, m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("data",  32'(bus.DATA_OUT), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk("count", 32'(bus.COUNT), 32'(q.size()));
    chk("empty", 32'(bus.EMPTY), 32'(q.size() == 0));
    chk("full",  32'(bus.FULL),  32'(q.size() == DEPTH));
    chk("irq",   32'(bus.IRQ),   32'(q.size() != 0));
    chk("ovf",   32'(bus.OVF),   32'(m_ovf));
    chk("caps",  32'(bus.CAPS_LED), 32'(m_caps));
  endtask

  task automatic translate(input byte unsigned c, output bit ok, output byte unsigned ch);
    ok = 1'b0;
    ch = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) begin
        ok = 1'b1;
        ch = 8'h61 + 8'(i);
        if ((m_shl | m_shr) ^ m_caps) ch = ch - 8'h20;
      end
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) begin ok = 1'b1; ch = 8'h30 + 8'(i); end
    if (c == 8'h29) begin ok = 1'b1; ch = 8'h20; end
    if (c == 8'h5A) begin ok = 1'b1; ch = 8'h0D; end
    if (c == 8'h66) begin ok = 1'b1; ch = 8'h08; end
  endtask

  task automatic key_event(input byte unsigned c, output bit push, output byte unsigned ch);
    push = 1'b0;
    ch   = 8'h00;
    if (m_ext) begin
      if (!m_brk && c == 8'hF0) m_brk = 1'b1;
      else begin m_ext = 1'b0; m_brk = 1'b0; end
    end else if (m_brk) begin
      if (c == 8'h12) m_shl = 1'b0;
      if (c == 8'h59) m_shr = 1'b0;
      m_brk = 1'b0;
    end else begin
      case (c)
        8'hF0:   m_brk  = 1'b1;
        8'hE0:   m_ext  = 1'b1;
        8'h12:   m_shl  = 1'b1;
        8'h59:   m_shr  = 1'b1;
        8'h58:   m_caps = ~m_caps;
        default: translate(c, push, ch);
      endcase
    end
  endtask

  // Advance one clock: update the model from current inputs, then compare.
  task automatic cycle();
    bit push, popped, ovf_evt;
    byte unsigned ch;
    push = 1'b0;
    ch   = 8'h00;
    if (bus.CODE_VALID && !m_cvq) key_event(bus.SCANCODE, push, ch);
    m_cvq   = bus.CODE_VALID;
    popped  = bus.RD_EN && (q.size() > 0);
    ovf_evt = push && (q.size() == DEPTH) && !popped;
    if (popped) void'(q.pop_front());
    if (push && !ovf_evt) q.push_back(ch);
    if (ovf_evt) m_ovf = 1'b1;
    else if (bus.OVF_CLR) m_ovf = 1'b0;
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic send(input byte unsigned c, input int len, input int gap, input bit rd_first);
    bus.CODE_VALID = 1'b1;
    bus.SCANCODE   = c;
    bus.RD_EN      = rd_first;
    cycle();
    bus.RD_EN = 1'b0;
    repeat (len - 1) cycle();
    bus.CODE_VALID = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic key(input byte unsigned c);
    send(c, 2, 1, 1'b0);
  endtask

  task automatic pop();
    bus.RD_EN = 1'b1;
    cycle();
    bus.RD_EN = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    q.delete();
    {m_shl, m_shr, m_caps, m_brk, m_ext, m_cvq, m_ovf} = '0;
    #1;
    check_all();
    @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    byte unsigned c;
    int unsigned sel;
    reset          = 1'b1;
    bus.CODE_VALID = 1'b0;
    bus.SCANCODE   = 8'h00;
    bus.RD_EN      = 1'b0;
    bus.OVF_CLR    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    chk("rst_empty", 32'(bus.EMPTY), 32'h1);
    chk("rst_data",  32'(bus.DATA_OUT), 32'h0);

    // long pulse yields one character
    send(8'h1C, 7, 2, 1'b0);
    chk("t1_data",  32'(bus.DATA_OUT), 32'h61);
    chk("t1_count", 32'(bus.COUNT), 32'h1);
    chk("t1_irq",   32'(bus.IRQ), 32'h1);
    pop();
    chk("t1_empty", 32'(bus.EMPTY), 32'h1);
    chk("t1_zero",  32'(bus.DATA_OUT), 32'h0);

    // shift press, key, shift release, key
    key(8'h12); key(8'h1C); key(8'hF0); key(8'h12); key(8'h1C);
    chk("sh_head", 32'(bus.DATA_OUT), 32'h41);
    pop();
    chk("sh_next", 32'(bus.DATA_OUT), 32'h61);
    pop();

    // caps lock and caps combined with shift
    key(8'h58);
    chk("caps_led", 32'(bus.CAPS_LED), 32'h1);
    key(8'h2A);
    chk("caps_v", 32'(bus.DATA_OUT), 32'h56);
    pop();
    key(8'h12); key(8'h2A);
    chk("caps_shift_v", 32'(bus.DATA_OUT), 32'h76);
    pop();
    key(8'hF0); key(8'h12); key(8'h16);
    chk("caps_digit", 32'(bus.DATA_OUT), 32'h31);
    pop();
    key(8'h58);

    // extended and unmapped codes push nothing
    key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75); key(8'hE0); key(8'h05);
    chk("ext_count", 32'(bus.COUNT), 32'h0);
    key(8'h1C);
    chk("ext_idle", 32'(bus.DATA_OUT), 32'h61);
    pop();

    // overflow: nine keys into eight slots
    for (int i = 0; i < 9; i++) key(letter_sc[i]);
    chk("ovf_full",  32'(bus.FULL), 32'h1);
    chk("ovf_count", 32'(bus.COUNT), 32'h8);
    chk("ovf_flag",  32'(bus.OVF), 32'h1);
    chk("ovf_head",  32'(bus.DATA_OUT), 32'h61);
    bus.OVF_CLR = 1'b1;
    cycle();
    bus.OVF_CLR = 1'b0;
    chk("ovf_clr", 32'(bus.OVF), 32'h0);
    send(letter_sc[20], 2, 1, 1'b1);
    chk("pp_count", 32'(bus.COUNT), 32'h8);
    chk("pp_ovf",   32'(bus.OVF), 32'h0);
    chk("pp_head",  32'(bus.DATA_OUT), 32'h62);
    repeat (8) pop();
    chk("drain_empty", 32'(bus.EMPTY), 32'h1);

    // reset in the middle of a break sequence
    key(8'h12); key(8'hF0);
    do_reset();
    key(8'h1C);
    chk("rst_mid", 32'(bus.DATA_OUT), 32'h61);
    pop();

    // pointer wrap
    for (int i = 0; i < 12; i++) begin
      key(letter_sc[$urandom_range(0, 25)]);
      pop();
    end

    // random keystrokes, pops and overflow clears
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: c = letter_sc[$urandom_range(0, 25)];
        3:       c = digit_sc[$urandom_range(0, 9)];
        4:       c = ($urandom_range(0, 1) == 0) ? 8'h29 : 8'h5A;
        5:       c = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        6:       c = 8'hF0;
        7:       c = 8'hE0;
        8:       c = 8'h58;
        default: c = 8'($urandom_range(0, 255));
      endcase
      bus.OVF_CLR = ($urandom_range(0, 15) == 0);
      send(c, int'($urandom_range(1, 4)), 0, ($urandom_range(0, 5) == 0));
      bus.OVF_CLR = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        bus.RD_EN   = ($urandom_range(0, 3) == 0);
        bus.OVF_CLR = ($urandom_range(0, 15) == 0);
        cycle();
        bus.RD_EN   = 1'b0;
        bus.OVF_CLR = 1'b0;
      end
      if (n == 250) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kbd_ascii_fifo.md
# kbd_ascii_fifo

Sits directly downstream of the PS/2 keyboard driver. It consumes the driver's interrupt pulse and scancode byte, tracks shift, caps-lock and prefix state, and translates make codes to ASCII. Translated characters are buffered in a small FIFO so the MCU can read them at its own pace through a pop handshake. It raises a level interrupt while characters are pending.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.

Ports:
- CLK  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-high.
- CODE_VALID  in  1  driver interrupt pulse; held high for one or more cycles per scancode.
- SCANCODE  in  8  driver scancode; stable whenever CODE_VALID=1.
- RD_EN  in  1  single-cycle pop request from the MCU.
- OVF_CLR  in  1  clears the sticky overflow flag.
- DATA_OUT  out  8  ASCII character at the FIFO head; 8'h00 when EMPTY.
- EMPTY  out  1  FIFO holds no characters.
- FULL  out  1  FIFO holds DEPTH characters.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- IRQ  out  1  equals ~EMPTY; level interrupt to the MCU.
- OVF  out  1  sticky flag; set when a character is dropped because the FIFO is full.
- CAPS_LED  out  1  current caps-lock state.

## Operation
- **Event detection.**
  - A register cv_q samples CODE_VALID each cycle.
  - An event occurs on any cycle where CODE_VALID=1 and cv_q=0.
  - A pulse of any length yields exactly one event.
- **Decoder FSM** (advances only on events):
  - IDLE:
    - F0 -> BREAK.
    - E0 -> EXT.
    - 12 -> shift_l=1; 59 -> shift_r=1.
    - 58 -> caps toggles.
    - Any other code: look it up; if it is mapped, push the character. Stay in IDLE.
  - BREAK, any code -> IDLE:
    - 12 clears shift_l; 59 clears shift_r.
    - All other codes are discarded.
  - EXT:
    - F0 -> EXT_BREAK.
    - Any other code is discarded -> IDLE. Extended keys are unmapped, so the driver's trailing lone E0 is absorbed here.
  - EXT_BREAK, any code -> IDLE, nothing pushed.
- **Lookup table** (hex scancode -> character):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Control: 29 -> 20 (space), 5A -> 0D (enter), 66 -> 08 (backspace).
  - Every other code is unmapped and is not pushed.
- **Case rule.**
  - Letters are uppercase (ASCII minus 8'h20) when (shift_l|shift_r) XOR caps.
  - Digits and control characters are unaffected by shift and caps.
- **FIFO.**
  - Storage is a register array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH. COUNT is kept separately.
  - Push when full without a pop: the character is dropped, OVF is set, and the pointers are unchanged.
  - Pop when empty: ignored; pointers and COUNT are unchanged.
  - Push and pop in the same cycle while full: both happen; COUNT stays DEPTH and OVF is not set.
  - Push and pop in the same cycle while empty: only the push happens; COUNT becomes 1.
  - OVF_CLR and an overflow in the same cycle: OVF remains set, because set wins.
- **Reset** (any time, including mid-sequence):
  - FSM -> IDLE; shift_l, shift_r, caps = 0; cv_q = 0.
  - Pointers and COUNT = 0.
  - Outputs: EMPTY=1, FULL=0, COUNT=0, IRQ=0, OVF=0, CAPS_LED=0, DATA_OUT=00.

## Timing
- All state updates occur on the rising edge of CLK; reset acts asynchronously.
- Push latency:
  - The event is decoded combinationally in the cycle where CODE_VALID first goes high.
  - The character is written at the end of that cycle.
  - EMPTY, IRQ, COUNT and DATA_OUT reflect the push in the next cycle.
- Pop: DATA_OUT is valid while EMPTY=0. When RD_EN=1 at an edge, the head advances and DATA_OUT shows the next entry (or 00) in the following cycle.
- FSM, shift and caps state update on the same edge as the event.
- CAPS_LED follows caps one cycle after the 58 event.
- The minimum event spacing supported is 2 cycles, since CODE_VALID must be low for at least one cycle between events.

## Test plan
- **Reset defaults and single key.** After reset, pulse CODE_VALID for 7 cycles with 1C.
  - Exactly one push: DATA_OUT=61, COUNT=1, IRQ=1.
  - RD_EN pulse -> EMPTY=1, DATA_OUT=00.
- **Shift with break.** Send 12, 1C, F0, 12, 1C.
  - FIFO holds 41 then 61.
  - The second F0 sequence leaves shift cleared.
- **Caps with shift.** Send 58, then 2A.
  - CAPS_LED=1 and 56 is pushed.
  - Then send 12, 2A -> 76 pushed.
  - Digit 16 under caps -> 31.
- **Extended and unmapped codes.** Send E0, 75, E0, F0, 75, E0, 05.
  - Nothing is pushed; COUNT=0; FSM ends in IDLE.
- **Overflow.** With DEPTH=8, push 9 mapped keys with no reads.
  - FULL=1, COUNT=8, OVF=1; the 9th character is lost.
  - A push with simultaneous RD_EN while full keeps COUNT=8, the head advances, and OVF is not re-set.
  - OVF_CLR -> OVF=0.
- **Reset mid-sequence.** Send 12, F0, then assert reset, release it, and send 1C.
  - Result is 61: shift cleared and the FSM is back in IDLE.
  - Pointer wrap: after 12 push/pop pairs, FIFO order is preserved.
